aha_ahb_lite_master: RTL

- Generic AHB-Lite initiator: converts a simple command/data-stream interface into AHB-Lite single or INCR transfers.
- Drives the code-region and system-bus slaves from non-CPU agents: debug loader, DMA-style test engines, and SoC verification harnesses.
- Handles only one command at a time.
- Supports burst lengths 1..16, 1KB boundary restart, wait states, BUSY insertion and ERROR cancellation.

---
 rtl/aha_ahb_lite_master.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/aha_ahb_lite_master.sv
// AHB-Lite initiator: turns one command plus a write-data stream into SINGLE/INCR
// transfers, with 1KB restart, BUSY insertion for starved writes and ERROR cancel.
module aha_ahb_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [3:0]        cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              done_err,
  output logic [4:0]        beats_done,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HWRITE,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  input  logic [DATA_W-1:0] HRDATA
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_ERR2, S_FIN} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [3:0]          len_q;
  logic                write_q;
  logic [4:0]          issue_cnt;
  logic [4:0]          comp_cnt;
  logic                dphase;
  logic                stg_full;
  logic [DATA_W-1:0]   stg_data;

  logic                addr_acc;
  logic                data_done;
  logic                err_now;
  logic [4:0]          total;
  logic [4:0]          fetched;
  logic [4:0]          next_issue;
  logic [ADDR_W-1:0]   incr;
  logic [ADDR_W-1:0]   beat_addr;
  logic                wr_take;
  logic                data_avail;
  logic                illegal;
  logic                unused_hresp;

  assign addr_acc   = HTRANS[1] & HREADY;
  assign data_done  = dphase & HREADY;
  assign err_now    = dphase & HRESP[0] & ~HREADY;
  assign total      = {1'b0, len_q} + 5'd1;
  assign fetched    = issue_cnt + {4'd0, stg_full};
  assign next_issue = issue_cnt + {4'd0, addr_acc};
  assign incr       = {{(ADDR_W-1){1'b0}}, 1'b1} << size_q;
  assign beat_addr  = addr_acc ? HADDR + incr : HADDR;
  assign illegal    = (size_q > 3'd2) || (size_q == 3'd1 && addr_q[0]) ||
                      (size_q == 3'd2 && addr_q[1:0] != 2'b00);

  assign cmd_ready  = (state == S_IDLE);
  // Staging may refill in the same cycle its beat is accepted, so gapless streams
  // produce back-to-back SEQ beats instead of a BUSY between every pair.
  assign wdata_ready = (state == S_RUN) && write_q && (!stg_full || addr_acc) &&
                       !err_now && (fetched < total);
  assign wr_take     = wdata_valid & wdata_ready;
  assign data_avail  = !write_q || (stg_full && !addr_acc) || wr_take;

  assign HPROT        = 4'b0011;
  assign unused_hresp = HRESP[1];

  // NOTE: every register here, including the staging data, is reset so an abort
  // leaves no stale beat that could later be driven onto HWDATA.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      len_q       <= '0;
      write_q     <= 1'b0;
      issue_cnt   <= '0;
      comp_cnt    <= '0;
      dphase      <= 1'b0;
      stg_full    <= 1'b0;
      stg_data    <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      done_err    <= 1'b0;
      beats_done  <= '0;
      HADDR       <= '0;
      HTRANS      <= TR_IDLE;
      HSIZE       <= '0;
      HBURST      <= '0;
      HWRITE      <= 1'b0;
      HWDATA      <= '0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block override
      // these pulse defaults without creating ordering hazards.
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;

      if (wr_take) begin
        stg_full <= 1'b1;
        stg_data <= wdata;
      end else if (addr_acc && write_q) begin
        stg_full <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q     <= cmd_addr;
            size_q     <= cmd_size;
            len_q      <= cmd_len;
            write_q    <= cmd_write;
            issue_cnt  <= '0;
            comp_cnt   <= '0;
            dphase     <= 1'b0;
            stg_full   <= 1'b0;
            beats_done <= '0;
            state      <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (illegal) begin
            done     <= 1'b1;
            done_err <= 1'b1;
            state    <= S_FIN;
          end else begin
            HADDR  <= addr_q;
            HSIZE  <= size_q;
            HWRITE <= write_q;
            HBURST <= (len_q == 4'd0) ? 3'b000 : 3'b001;
            HTRANS <= write_q ? TR_IDLE : TR_NONSEQ;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          if (err_now) begin
            HTRANS   <= TR_IDLE;
            stg_full <= 1'b0;
            state    <= S_ERR2;
          end else begin
            if (data_done) begin
              comp_cnt <= comp_cnt + 5'd1;
              if (!write_q) begin
                rdata       <= HRDATA;
                rdata_valid <= 1'b1;
              end
            end
            if (addr_acc) begin
              issue_cnt <= next_issue;
              dphase    <= 1'b1;
              if (write_q) HWDATA <= stg_data;
            end else if (data_done) begin
              dphase <= 1'b0;
            end
            // A pending address phase stays frozen until the slave takes it.
            if (!(HTRANS[1] && !HREADY)) begin
              if (next_issue == total) begin
                HTRANS <= TR_IDLE;
                state  <= S_DRAIN;
              end else begin
                HADDR <= beat_addr;
                if (data_avail)
                  HTRANS <= (next_issue == 5'd0 || beat_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                else
                  HTRANS <= (next_issue == 5'd0) ? TR_IDLE : TR_BUSY;
              end
            end
          end
        end

        S_DRAIN: begin
          if (err_now) begin
            state <= S_ERR2;
          end else if (data_done) begin
            dphase     <= 1'b0;
            comp_cnt   <= comp_cnt + 5'd1;
            beats_done <= comp_cnt + 5'd1;
            done       <= 1'b1;
            state      <= S_FIN;
            if (!write_q) begin
              rdata       <= HRDATA;
              rdata_valid <= 1'b1;
            end
          end
        end

        S_ERR2: begin
          if (HREADY) begin
            dphase     <= 1'b0;
            beats_done <= comp_cnt;
            done       <= 1'b1;
            done_err   <= 1'b1;
            state      <= S_FIN;
          end
        end

        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
